// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction field layout, opcodes,
// multdiv ALU codes and the interlock FSM state type.
package proc_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned REG_W     = 5;

    // Field LSB positions: op=[31:27] rd=[26:22] rs=[21:17] rt=[16:12] aluop=[6:2]
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_LSB    = 17;
    localparam int unsigned RT_LSB    = 12;
    localparam int unsigned ALUOP_LSB = 2;

    localparam logic [REG_W-1:0] OP_ALU  = 5'd0;
    localparam logic [REG_W-1:0] OP_BNE  = 5'd2;
    localparam logic [REG_W-1:0] OP_JR   = 5'd4;
    localparam logic [REG_W-1:0] OP_ADDI = 5'd5;
    localparam logic [REG_W-1:0] OP_BLT  = 5'd6;
    localparam logic [REG_W-1:0] OP_SW   = 5'd7;
    localparam logic [REG_W-1:0] OP_LW   = 5'd8;

    localparam logic [REG_W-1:0] ALUOP_MUL = 5'd6;
    localparam logic [REG_W-1:0] ALUOP_DIV = 5'd7;

    localparam logic [INSTR_W-1:0] NOP = 32'b0;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

endpackage

// File: rtl/stall_control_if.sv
// Pipeline-to-interlock signal bundle. The pipeline (master) supplies the
// latched instructions and resolution/handshake inputs; the interlock (slave)
// returns latch enables, bubbles, flushes and multdiv control.
// STALL_COUNT_EN adds the stall_count field and its CNT_W parameter.
interface stall_control_if
`ifdef STALL_COUNT_EN
    #(parameter int unsigned CNT_W = 32)
`endif
    ;
    logic [31:0] FDIR;
    logic [31:0] DXIR;
    logic        branch_taken;
    logic        md_ready;
    logic        pc_we;
    logic        fd_we;
    logic        dx_we;
    logic        fd_flush;
    logic        dx_bubble;
    logic        xm_bubble;
    logic        md_start;
    logic        md_busy;
    logic        md_timeout;
`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] stall_count;

    modport master (
        output FDIR, DXIR, branch_taken, md_ready,
        input  pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble,
        input  md_start, md_busy, md_timeout, stall_count
    );
    modport slave (
        input  FDIR, DXIR, branch_taken, md_ready,
        output pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble,
        output md_start, md_busy, md_timeout, stall_count
    );
`else
    modport master (
        output FDIR, DXIR, branch_taken, md_ready,
        input  pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble,
        input  md_start, md_busy, md_timeout
    );
    modport slave (
        input  FDIR, DXIR, branch_taken, md_ready,
        output pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble,
        output md_start, md_busy, md_timeout
    );
`endif
endinterface

// File: rtl/stall_control_hazard_decode.sv
// Combinational hazard decode: load-use between the lw in D/X and the
// instruction in F/D, and detection of a mult/div in D/X.
module hazard_decode
    import proc_pkg::*;
(
    input  logic [INSTR_W-1:0] fdIr,
    input  logic [INSTR_W-1:0] dxIr,
    output logic               loadUse_c,
    output logic               dxIsMd_c
);

    logic [REG_W-1:0] fdOp, fdRd, fdRs, fdRt;
    logic [REG_W-1:0] dxOp, dxRd, dxAluOp;
    logic             useRd, useRs, useRt;
    logic             unusedBits;

    assign fdOp    = fdIr[OP_LSB    +: REG_W];
    assign fdRd    = fdIr[RD_LSB    +: REG_W];
    assign fdRs    = fdIr[RS_LSB    +: REG_W];
    assign fdRt    = fdIr[RT_LSB    +: REG_W];
    assign dxOp    = dxIr[OP_LSB    +: REG_W];
    assign dxRd    = dxIr[RD_LSB    +: REG_W];
    assign dxAluOp = dxIr[ALUOP_LSB +: REG_W];

    // Immediates, shamt and unused D/X source fields play no part here
    assign unusedBits = ^{fdIr[11:0], dxIr[21:7], dxIr[1:0]};

    // Register fields read by the F/D instruction; sw data (rd) is bypassed in memory
    always_comb begin
        useRd = 1'b0;
        useRs = 1'b0;
        useRt = 1'b0;
        case (fdOp)
            OP_ALU:               begin useRs = 1'b1; useRt = 1'b1; end
            OP_ADDI, OP_LW, OP_SW: useRs = 1'b1;
            OP_BNE, OP_BLT:       begin useRd = 1'b1; useRs = 1'b1; end
            OP_JR:                 useRd = 1'b1;
            default:               ;
        endcase
    end

    assign loadUse_c = (dxOp == OP_LW) && (dxRd != '0) &&
                       ((useRd && (fdRd == dxRd)) ||
                        (useRs && (fdRs == dxRd)) ||
                        (useRt && (fdRt == dxRd)));

    assign dxIsMd_c  = (dxOp == OP_ALU) &&
                       ((dxAluOp == ALUOP_MUL) || (dxAluOp == ALUOP_DIV));

endmodule

// File: rtl/stall_control.sv
// Pipeline interlock: stalls load-use hazards, waits on the multdiv unit and
// flushes wrong-path instructions on a taken branch in X.
// STALL_COUNT_EN enables the saturating stall_count output.
module stall_control
    import proc_pkg::*;
#(
`ifdef STALL_COUNT_EN
    parameter int unsigned CNT_W      = 32,
`endif
    parameter int unsigned MD_TIMEOUT = 40
) (
    input  logic            clock,
    input  logic            reset_n,
    stall_control_if.slave  bus
);

    localparam int unsigned WAIT_W = $clog2(MD_TIMEOUT);

    mdState_t          state, nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic              timeoutFlag;
    logic              timeoutHit;
    logic              loadUse, dxIsMd;
    logic              pcWe, fdWe, dxWe;
    logic              fdFlush, dxBubble, xmBubble;
    logic              mdStart, mdBusy;

    hazard_decode uDecode (
        .fdIr      (bus.FDIR),
        .dxIr      (bus.DXIR),
        .loadUse_c (loadUse),
        .dxIsMd_c  (dxIsMd)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= nextState;
    end

    // Next state and interlock controls; reset forces free-running, no-bubble outputs
    always_comb begin
        nextState  = state;
        pcWe       = 1'b1;
        fdWe       = 1'b1;
        dxWe       = 1'b1;
        fdFlush    = 1'b0;
        dxBubble   = 1'b0;
        xmBubble   = 1'b0;
        mdStart    = 1'b0;
        mdBusy     = 1'b0;
        timeoutHit = 1'b0;
        if (!reset_n) begin
            nextState = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (bus.branch_taken) begin
                        fdFlush  = 1'b1;
                        dxBubble = 1'b1;
                    end else if (dxIsMd) begin
                        mdStart   = 1'b1;
                        pcWe      = 1'b0;
                        fdWe      = 1'b0;
                        dxWe      = 1'b0;
                        xmBubble  = 1'b1;
                        nextState = MD_BUSY;
                    end else if (loadUse) begin
                        pcWe     = 1'b0;
                        fdWe     = 1'b0;
                        dxBubble = 1'b1;
                    end
                end
                MD_BUSY: begin
                    mdBusy = 1'b1;
                    if (bus.md_ready) begin
                        nextState = RUN;
                    end else if (waitCnt == WAIT_W'(MD_TIMEOUT - 1)) begin
                        timeoutHit = 1'b1;
                        nextState  = RUN;
                    end else begin
                        pcWe     = 1'b0;
                        fdWe     = 1'b0;
                        dxWe     = 1'b0;
                        xmBubble = 1'b1;
                    end
                end
                default: nextState = RUN;
            endcase
        end
    end

    // Multdiv wait counter and sticky watchdog flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            waitCnt     <= '0;
            timeoutFlag <= 1'b0;
        end else begin
            if ((state == MD_BUSY) && (nextState == MD_BUSY)) waitCnt <= waitCnt + WAIT_W'(1);
            else                                              waitCnt <= '0;
            if (timeoutHit) timeoutFlag <= 1'b1;
        end
    end

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] stallCnt;

    // Saturating count of cycles with the PC held
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                     stallCnt <= '0;
        else if (!pcWe && (stallCnt != '1)) stallCnt <= stallCnt + CNT_W'(1);
    end

    assign bus.stall_count = stallCnt;
`endif

    assign bus.pc_we      = pcWe;
    assign bus.fd_we      = fdWe;
    assign bus.dx_we      = dxWe;
    assign bus.fd_flush   = fdFlush;
    assign bus.dx_bubble  = dxBubble;
    assign bus.xm_bubble  = xmBubble;
    assign bus.md_start   = mdStart;
    assign bus.md_busy    = mdBusy;
    assign bus.md_timeout = timeoutFlag;

endmodule

// File: tb/tb_stall_control.sv
// Self-checking bench for stall_control: directed hazard scenarios followed by
// randomized instruction pairs, checked against a behavioural interlock model.
module tb_stall_control;
    import proc_pkg::*;

    localparam int TB_MD_TIMEOUT = 40;

    // Output vector order: {pc_we,fd_we,dx_we,fd_flush,dx_bubble,xm_bubble,md_start,md_busy,md_timeout}
    localparam logic [8:0] P_RUN   = 9'b111_000_000;
    localparam logic [8:0] P_LU    = 9'b001_010_000;
    localparam logic [8:0] P_FLUSH = 9'b111_110_000;
    localparam logic [8:0] P_START = 9'b000_001_100;
    localparam logic [8:0] P_HOLD  = 9'b000_001_010;
    localparam logic [8:0] P_REL   = 9'b111_000_010;

    logic clock;
    logic reset_n;

`ifdef STALL_COUNT_EN
    stall_control_if #(.CNT_W(32)) bus ();
    stall_control #(.CNT_W(32), .MD_TIMEOUT(TB_MD_TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus));
`else
    stall_control_if bus ();
    stall_control #(.MD_TIMEOUT(TB_MD_TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus));
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [8:0] outs;
    assign outs = {bus.pc_we, bus.fd_we, bus.dx_we, bus.fd_flush, bus.dx_bubble,
                   bus.xm_bubble, bus.md_start, bus.md_busy, bus.md_timeout};

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural model state: multdiv outstanding, busy cycles already waited
    bit mActive;
    int mWaited;
    bit mTimeout;
    int stalls;

    function automatic logic [31:0] mkInstr(input int op, input int rd, input int rs,
                                            input int rt, input int aluop);
        return {5'(op), 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(aluop), 2'b00};
    endfunction

    function automatic bit isMdOp(input logic [31:0] ir);
        int op = int'(ir[31:27]);
        int fn = int'(ir[6:2]);
        return (op == 0) && (fn == 6 || fn == 7);
    endfunction

    // Load-use: lw writes a nonzero register the F/D instruction reads
    function automatic bit hazard(input logic [31:0] fd, input logic [31:0] dx);
        int srcs[$];
        int dest = int'(dx[26:22]);
        if (int'(dx[31:27]) != 8 || dest == 0) return 1'b0;
        case (int'(fd[31:27]))
            0:       begin srcs.push_back(int'(fd[21:17])); srcs.push_back(int'(fd[16:12])); end
            5, 7, 8: srcs.push_back(int'(fd[21:17]));
            2, 6:    begin srcs.push_back(int'(fd[26:22])); srcs.push_back(int'(fd[21:17])); end
            4:       srcs.push_back(int'(fd[26:22]));
            default: ;
        endcase
        foreach (srcs[i]) if (srcs[i] == dest) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelStep(input logic [31:0] fd, input logic [31:0] dx,
                             input logic bt, input logic rdy, output logic [8:0] exp);
        bit pc = 1, fdw = 1, dxw = 1, fl = 0, dxb = 0, xmb = 0, st = 0, bsy = 0;
        bit setTimeout = 0;
        if (!mActive) begin
            if (bt) begin
                fl = 1; dxb = 1;
            end else if (isMdOp(dx)) begin
                st = 1; pc = 0; fdw = 0; dxw = 0; xmb = 1;
                mActive = 1; mWaited = 0;
            end else if (hazard(fd, dx)) begin
                pc = 0; fdw = 0; dxb = 1;
            end
        end else begin
            bsy = 1;
            if (rdy || (mWaited + 1 == TB_MD_TIMEOUT)) begin
                setTimeout = !rdy;
                mActive = 0;
            end else begin
                pc = 0; fdw = 0; dxw = 0; xmb = 1;
                mWaited++;
            end
        end
        exp = {pc, fdw, dxw, fl, dxb, xmb, st, bsy, mTimeout};
        if (setTimeout) mTimeout = 1;
        if (!pc) stalls++;
    endtask

    task automatic stepCycle(input string tag, input logic [31:0] fd, input logic [31:0] dx,
                             input logic bt, input logic rdy, output logic [8:0] got);
        logic [8:0] exp;
        int stallsBefore;
        @(negedge clock);
        bus.FDIR = fd; bus.DXIR = dx; bus.branch_taken = bt; bus.md_ready = rdy;
        #2;
        stallsBefore = stalls;
        modelStep(fd, dx, bt, rdy, exp);
        got = outs;
        checkVal(tag, 64'(got), 64'(exp));
`ifdef STALL_COUNT_EN
        checkVal({tag, "_cnt"}, 64'(bus.stall_count), 64'(stallsBefore));
`else
        if (stallsBefore < 0) checkVal({tag, "_cnt"}, 64'(stallsBefore), 64'(0));
`endif
    endtask

    task automatic resetPulse(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            reset_n = 1'b0;
            #2;
            checkVal("rst_outs", 64'(outs), 64'(P_RUN));
`ifdef STALL_COUNT_EN
            checkVal("rst_cnt", 64'(bus.stall_count), 64'(0));
`endif
        end
        mActive = 0; mWaited = 0; mTimeout = 0; stalls = 0;
        bus.FDIR = NOP; bus.DXIR = NOP; bus.branch_taken = 1'b0; bus.md_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #2;
        checkVal("post_rst_outs", 64'(outs), 64'(P_RUN));
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] ir = $urandom;
        int op;
        case ($urandom_range(0, 9))
            0: op = 0;  1: op = 2;  2: op = 4;  3: op = 5;  4: op = 6;
            5: op = 7;  6: op = 8;  7: op = 0;  8: op = 1;  default: op = 9;
        endcase
        ir[31:27] = 5'(op);
        ir[26:22] = 5'($urandom_range(0, 3));
        ir[21:17] = 5'($urandom_range(0, 3));
        ir[16:12] = 5'($urandom_range(0, 3));
        ir[6:2]   = 5'($urandom_range(0, 7));
        return ir;
    endfunction

    logic [31:0] lw3, addUse3, sw3, lw0, add0, mulI, bneUse3;
    logic [8:0]  got;
    int          cnt;
    logic [31:0] curDx, fdR;

    initial begin
        mActive = 0; mWaited = 0; mTimeout = 0; stalls = 0;
        lw3     = mkInstr(8, 3, 1, 0, 0);
        addUse3 = mkInstr(0, 4, 3, 5, 0);
        sw3     = mkInstr(7, 3, 2, 0, 0);
        lw0     = mkInstr(8, 0, 1, 0, 0);
        add0    = mkInstr(0, 4, 0, 0, 0);
        mulI    = mkInstr(0, 6, 1, 2, 6);
        bneUse3 = mkInstr(2, 4, 3, 0, 0);

        // Reset with a mult in D/X: enables high, no start
        reset_n = 1'b0;
        bus.FDIR = addUse3; bus.DXIR = mulI; bus.branch_taken = 1'b0; bus.md_ready = 1'b0;
        #2;
        checkVal("init_rst_outs", 64'(outs), 64'(P_RUN));
        resetPulse(2);

        // Load-use: one-cycle hold, then the bubble lets FD proceed
        stepCycle("lu_hold", addUse3, lw3, 1'b0, 1'b0, got);
        checkVal("lu_hold_pat", 64'(got), 64'(P_LU));
        stepCycle("lu_after", addUse3, NOP, 1'b0, 1'b0, got);
        checkVal("lu_after_pat", 64'(got), 64'(P_RUN));

        // sw data and $0 are never hazards; bne source is
        stepCycle("sw_bypass", sw3, lw3, 1'b0, 1'b0, got);
        checkVal("sw_bypass_pat", 64'(got), 64'(P_RUN));
        stepCycle("lw_r0", add0, lw0, 1'b0, 1'b0, got);
        checkVal("lw_r0_pat", 64'(got), 64'(P_RUN));

        // Taken branch overrides load-use and md start
        stepCycle("br_lu", addUse3, lw3, 1'b1, 1'b0, got);
        checkVal("br_lu_pat", 64'(got), 64'(P_FLUSH));
        stepCycle("br_md", addUse3, mulI, 1'b1, 1'b0, got);
        checkVal("br_md_pat", 64'(got), 64'(P_FLUSH));

        // Multdiv with ready on the start cycle (ignored), 5 holds, ready release
        stepCycle("md_start", addUse3, mulI, 1'b0, 1'b1, got);
        checkVal("md_start_pat", 64'(got), 64'(P_START));
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            stepCycle("md_hold", addUse3, mulI, 1'b0, 1'b0, got);
            if (got == P_HOLD) cnt++;
        end
        checkVal("md_hold_cycles", 64'(cnt), 64'(5));
        stepCycle("md_rel", addUse3, mulI, 1'b0, 1'b1, got);
        checkVal("md_rel_pat", 64'(got), 64'(P_REL));
        stepCycle("md_post", bneUse3, NOP, 1'b0, 1'b0, got);
        checkVal("md_post_pat", 64'(got), 64'(P_RUN));
`ifdef STALL_COUNT_EN
        checkVal("md_stall_count", 64'(bus.stall_count), 64'(7));
`endif

        // Watchdog: no md_ready, release after 40 busy cycles, flag sticks
        stepCycle("to_start", NOP, mulI, 1'b0, 1'b0, got);
        cnt = 0;
        for (int i = 0; i < TB_MD_TIMEOUT; i++) begin
            stepCycle("to_busy", NOP, mulI, 1'b0, 1'b0, got);
            if (got[1]) cnt++;
            if (i == TB_MD_TIMEOUT - 1) checkVal("to_rel_pat", 64'(got), 64'(P_REL));
        end
        checkVal("to_busy_cycles", 64'(cnt), 64'(TB_MD_TIMEOUT));
        stepCycle("to_after", NOP, NOP, 1'b0, 1'b0, got);
        checkVal("to_flag_set", 64'(got), 64'(P_RUN | 9'b1));
        stepCycle("to_sticky", add0, NOP, 1'b0, 1'b1, got);
        checkVal("to_flag_sticky", 64'(got[0]), 64'(1));

        // Reset mid-MD_BUSY returns to RUN and clears the watchdog flag
        stepCycle("rb_start", NOP, mulI, 1'b0, 1'b0, got);
        stepCycle("rb_hold", NOP, mulI, 1'b0, 1'b0, got);
        stepCycle("rb_hold", NOP, mulI, 1'b0, 1'b0, got);
        @(negedge clock);
        bus.DXIR = mulI;
        resetPulse(2);

        // Randomized instruction pairs; D/X is held while multdiv is outstanding
        curDx = NOP;
        for (int i = 0; i < 600; i++) begin
            logic bt, rdy;
            fdR = randInstr();
            if (!mActive) begin
                case ($urandom_range(0, 7))
                    0:       curDx = mkInstr(0, $urandom_range(0, 3), 1, 2, $urandom_range(6, 7));
                    1, 2, 3: curDx = mkInstr(8, $urandom_range(0, 3), 1, 0, 0);
                    default: curDx = randInstr();
                endcase
            end
            bt  = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 3) == 0);
            stepCycle("rand", fdR, curDx, bt, rdy, got);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
